// File: rtl/config_pkg.sv
// config_pkg: constants and types shared by the configuration loader and its
// frame assembler.
// Optional build macro: CONFIG_LOADER_CHECKSUM_EN (each frame carries a ninth
// byte holding the XOR of bytes 0-7).
package config_pkg;

  // Unit select values carried in the upper address half; tiles decode these.
  localparam int unsigned CONFIG_SB  = 7;
  localparam int unsigned CONFIG_CB0 = 6;
  localparam int unsigned CONFIG_CB1 = 5;
  localparam int unsigned CONFIG_CLB = 4;

  // Resting bus address (selects no unit) and the end-of-stream frame address.
  localparam logic [31:0] IDLE_ADDR_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] END_ADDR_DEFAULT  = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    DONE    = 2'd2
  } loader_state_t;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = 9;
`else
  localparam int unsigned FRAME_BYTES = 8;
`endif

  localparam int unsigned BYTE_IDX_W = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/config_loader_if.sv
// config_loader_if: byte-stream input handshake plus the broadcast config bus
// and loader status. The loader uses the slave modport; the byte source and
// bus observers use the master modport.
// Optional build macro: CONFIG_LOADER_CHECKSUM_EN adds err_count.
interface config_loader_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_done;
  logic        busy;
  logic [15:0] frame_count;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [7:0]  err_count;
`endif

  modport slave (
    input  in_byte, in_valid,
    output in_ready, config_addr, config_data, config_done, busy, frame_count
`ifdef CONFIG_LOADER_CHECKSUM_EN
    , output err_count
`endif
  );

  modport master (
    output in_byte, in_valid,
    input  in_ready, config_addr, config_data, config_done, busy, frame_count
`ifdef CONFIG_LOADER_CHECKSUM_EN
    , input err_count
`endif
  );
endinterface

// File: rtl/config_frame_assembler.sv
// config_frame_assembler: tracks the byte position inside a frame, shifts the
// address and data shadows MSB first, and flags the final byte of a frame.
// Optional build macro: CONFIG_LOADER_CHECKSUM_EN (running XOR check on byte 8).
module config_frame_assembler
  import config_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_take,
  output logic [31:0] addr_shadow,
  output logic [31:0] data_shadow,
  output logic        frame_ready,
  output logic        frame_ok
);

  logic [BYTE_IDX_W-1:0] idx_reg;
  logic [31:0]           addr_reg;
  logic [31:0]           data_reg;
  logic                  last_byte;

  assign last_byte   = (idx_reg == BYTE_IDX_W'(FRAME_BYTES - 1));
  // Combinational so the loader can leave COLLECT on the same edge that
  // accepts the final byte.
  assign frame_ready = byte_take && last_byte;
  assign addr_shadow = addr_reg;
  assign data_shadow = data_reg;

  // Byte position within the frame; holds while no byte is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg <= '0;
    end else if (byte_take) begin
      idx_reg <= last_byte ? '0 : idx_reg + 1'b1;
    end
  end

  // Shadow shift registers: bytes 0-3 build the address, bytes 4-7 the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg <= '0;
      data_reg <= '0;
    end else if (byte_take) begin
      if (idx_reg < BYTE_IDX_W'(4)) begin
        addr_reg <= {addr_reg[23:0], byte_data};
      end else if (idx_reg < BYTE_IDX_W'(8)) begin
        data_reg <= {data_reg[23:0], byte_data};
      end
    end
  end

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;

  // Running XOR of bytes 0-7; a correct checksum byte cancels it to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_reg <= 8'h00;
    end else if (byte_take) begin
      csum_reg <= last_byte ? 8'h00 : (csum_reg ^ byte_data);
    end
  end

  assign frame_ok = ((csum_reg ^ byte_data) == 8'h00);
`else
  assign frame_ok = 1'b1;
`endif

endmodule

// File: rtl/config_loader.sv
// config_loader: turns a big-endian byte stream of addr/data frames into the
// fabric-wide config_addr/config_data broadcast. Each decoded write is held
// for HOLD_CYCLES cycles, the bus otherwise rests on IDLE_ADDR, and a frame
// addressed to END_ADDR raises config_done until reset.
// Optional build macro: CONFIG_LOADER_CHECKSUM_EN (9-byte frames with XOR
// checksum; bad frames are dropped and counted in err_count).
module config_loader
  import config_pkg::*;
#(
  parameter logic [31:0] IDLE_ADDR   = IDLE_ADDR_DEFAULT,
  parameter logic [31:0] END_ADDR    = END_ADDR_DEFAULT,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  config_loader_if.slave  bus
);

  // Value loaded into the hold counter on entering ISSUE. The first ISSUE
  // cycle copies the shadows onto the bus; the counter then runs down to 0,
  // giving exactly HOLD_CYCLES cycles of the frame on the bus.
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

  loader_state_t state_reg, state_next;
  logic [3:0]    hold_reg, hold_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   data_reg, data_next;
  logic [15:0]   count_reg, count_next;
  logic          done_reg, done_next;
  logic          ready_reg, ready_next;
  logic          busy_c;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [7:0]    err_reg, err_next;
`endif

  logic [31:0] addr_shadow;
  logic [31:0] data_shadow;
  logic        frame_ready;
  logic        frame_ok;
  logic        byte_take;

  assign byte_take = bus.in_valid && ready_reg;

  config_frame_assembler u_assembler (
    .clk         (clk),
    .reset       (reset),
    .byte_data   (bus.in_byte),
    .byte_take   (byte_take),
    .addr_shadow (addr_shadow),
    .data_shadow (data_shadow),
    .frame_ready (frame_ready),
    .frame_ok    (frame_ok)
  );

  // Next-state, bus and status decisions for the COLLECT/ISSUE/DONE sequence.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    count_next = count_reg;
    done_next  = done_reg;
    busy_c     = 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    err_next   = err_reg;
`endif
    unique case (state_reg)
      COLLECT: begin
        if (frame_ready) begin
          if (!frame_ok) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
            err_next = sat_inc8(err_reg);
`endif
          end else if (addr_shadow == END_ADDR) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = ISSUE;
            hold_next  = HOLD_LOAD;
          end
        end
      end
      ISSUE: begin
        busy_c = 1'b1;
        if (hold_reg == HOLD_LOAD) begin
          addr_next  = addr_shadow;
          data_next  = data_shadow;
          count_next = sat_inc16(count_reg);
        end
        if (hold_reg == 4'd0) begin
          state_next = COLLECT;
          addr_next  = IDLE_ADDR;
        end else begin
          hold_next = hold_reg - 4'd1;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = COLLECT;
        addr_next  = IDLE_ADDR;
      end
    endcase
    // Registered so in_ready reads 0 throughout reset.
    ready_next = (state_next == COLLECT);
  end

  // State register and hold counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= COLLECT;
      hold_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  // Bus drivers and status registers; reset parks the bus on IDLE_ADDR at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg  <= IDLE_ADDR;
      data_reg  <= 32'h0;
      count_reg <= 16'h0;
      done_reg  <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      count_reg <= count_next;
      done_reg  <= done_next;
      ready_reg <= ready_next;
    end
  end

`ifdef CONFIG_LOADER_CHECKSUM_EN
  // Saturating count of frames dropped for a bad checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg <= 8'h00;
    end else begin
      err_reg <= err_next;
    end
  end

  assign bus.err_count = err_reg;
`endif

  assign bus.in_ready    = ready_reg;
  assign bus.config_addr = addr_reg;
  assign bus.config_data = data_reg;
  assign bus.config_done = done_reg;
  assign bus.busy        = busy_c;
  assign bus.frame_count = count_reg;

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: drives two loaders (HOLD_CYCLES=1 and 3) with frame byte
// streams and compares every bus write against frames predicted from the
// bytes sent: one write per good frame, held HOLD cycles from the edge after
// its last byte. Honors CONFIG_LOADER_CHECKSUM_EN.
module tb_config_loader;
  import config_pkg::*;

  localparam logic [31:0] IDLE_A = 32'hFFFF_FFFF;
  localparam logic [31:0] END_A  = 32'hFFFF_FFFE;
  localparam int H_A = 1;
  localparam int H_B = 3;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          edge_n;
    logic        rdy;
    logic        busy;
  } bus_ev_t;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;
  int   cnt_a    = 0;
  int   cnt_b    = 0;
  bus_ev_t q_a[$];
  bus_ev_t q_b[$];

  config_loader_if if_a ();
  config_loader_if if_b ();

  config_loader #(.HOLD_CYCLES(H_A)) dut_a (.clk(clk), .reset(rst_a), .bus(if_a.slave));
  config_loader #(.HOLD_CYCLES(H_B)) dut_b (.clk(clk), .reset(rst_b), .bus(if_b.slave));

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Record every cycle the bus carries a non-idle address, tagged by edge.
  always @(negedge clk) begin
    if (!rst_a && if_a.config_addr !== IDLE_A)
      q_a.push_back('{addr: if_a.config_addr, data: if_a.config_data, edge_n: edge_cnt,
                      rdy: if_a.in_ready, busy: if_a.busy});
    if (!rst_b && if_b.config_addr !== IDLE_A)
      q_b.push_back('{addr: if_b.config_addr, data: if_b.config_data, edge_n: edge_cnt,
                      rdy: if_b.in_ready, busy: if_b.busy});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  task automatic drive(input int sel, input logic v, input logic [7:0] b);
    if (sel == 0) begin if_a.in_valid = v; if_a.in_byte = b; end
    else          begin if_b.in_valid = v; if_b.in_byte = b; end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? if_a.in_ready : if_b.in_ready;
  endfunction

  function automatic bytes_t make_frame(input logic [31:0] a, input logic [31:0] d, input bit bad);
    bytes_t q;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 3; i >= 0; i--) q.push_back(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) q.push_back(d[i*8 +: 8]);
`ifdef CONFIG_LOADER_CHECKSUM_EN
    foreach (q[i]) x = x ^ q[i];
    q.push_back(bad ? ~x : x);
`else
    if (bad) x = 8'hFF;
`endif
    return q;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    if (a >= END_A) a = 32'h1234_0000;
    return a;
  endfunction

  // Present one byte from the next falling edge and wait for it to be taken.
  task automatic send_byte(input int sel, input logic [7:0] b, output int acc);
    int waited;
    waited = 0;
    acc = -1;
    @(negedge clk);
    drive(sel, 1'b1, b);
    while (!get_ready(sel) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (get_ready(sel) === 1'b1) acc = edge_cnt + 1;
    else begin
      failures++;
      $display("FAIL send_byte dut=%0d in_ready=%b required=1 within 50 cycles", sel, get_ready(sel));
    end
  endtask

  task automatic send_frame(input int sel, input bytes_t fb, input int gap_after, input int gap_len,
                            output int first_acc, output int last_acc);
    int acc;
    first_acc = -1;
    last_acc  = -1;
    foreach (fb[i]) begin
      send_byte(sel, fb[i], acc);
      if (i == 0) first_acc = acc;
      last_acc = acc;
      if (i == gap_after && gap_len > 0) begin
        @(negedge clk);
        drive(sel, 1'b0, 8'h00);
        repeat (gap_len - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    drive(sel, 1'b0, 8'h00);
  endtask

  task automatic pop_ev(input int sel, output bit found, output bus_ev_t ev);
    found = 1'b0;
    ev = '{addr: 32'h0, data: 32'h0, edge_n: -1, rdy: 1'bx, busy: 1'bx};
    if (sel == 0 && q_a.size() > 0) begin ev = q_a.pop_front(); found = 1'b1; end
    else if (sel == 1 && q_b.size() > 0) begin ev = q_b.pop_front(); found = 1'b1; end
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (if_a.config_addr !== IDLE_A) begin failures++;
      $display("FAIL reset_addr got=%h exp=%h", if_a.config_addr, IDLE_A); end
    checks++; if (if_a.config_data !== 32'h0) begin failures++;
      $display("FAIL reset_data got=%h exp=0", if_a.config_data); end
    checks++; if (if_a.in_ready !== 1'b0) begin failures++;
      $display("FAIL reset_in_ready got=%b exp=0", if_a.in_ready); end
    checks++; if (if_a.config_done !== 1'b0 || if_a.busy !== 1'b0) begin failures++;
      $display("FAIL reset_done_busy got=%b/%b exp=0/0", if_a.config_done, if_a.busy); end
    checks++; if (if_a.frame_count !== 16'h0) begin failures++;
      $display("FAIL reset_frame_count got=%0d exp=0", if_a.frame_count); end
`ifdef CONFIG_LOADER_CHECKSUM_EN
    checks++; if (if_b.err_count !== 8'h0) begin failures++;
      $display("FAIL reset_err_count got=%0d exp=0", if_b.err_count); end
`endif
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    checks++; if (if_a.in_ready !== 1'b1 || if_b.in_ready !== 1'b1) begin failures++;
      $display("FAIL release_in_ready got=%b/%b exp=1/1", if_a.in_ready, if_b.in_ready); end
    q_a.delete();
    q_b.delete();
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single_frame();
    bytes_t fb; int f, l; bus_ev_t ev; bit found;
    fb = make_frame(32'h0007_0003, 32'h0000_0015, 1'b0);
    send_frame(0, fb, -1, 0, f, l);
    cnt_a++;
    repeat (H_A + 4) @(negedge clk);
    pop_ev(0, found, ev);
    checks++; if (!found || ev.edge_n != l + 1 || ev.addr !== 32'h0007_0003 || ev.data !== 32'h15) begin
      failures++;
      $display("FAIL single_write found=%0d edge=%0d addr=%h data=%h exp edge=%0d addr=00070003 data=00000015",
               found, ev.edge_n, ev.addr, ev.data, l + 1); end
    checks++; if (q_a.size() != 0) begin failures++;
      $display("FAIL single_extra_cycles got=%0d exp=0", q_a.size()); q_a.delete(); end
    checks++; if (if_a.frame_count !== 16'(cnt_a)) begin failures++;
      $display("FAIL single_frame_count got=%0d exp=%0d", if_a.frame_count, cnt_a); end
    checks++; if (if_a.config_addr !== IDLE_A || if_a.config_data !== 32'h15) begin failures++;
      $display("FAIL single_after addr=%h data=%h exp addr=%h data=00000015", if_a.config_addr, if_a.config_data, IDLE_A); end
    $display("test_single_frame last_byte_edge=%0d write_edge=%0d", l, ev.edge_n);
  endtask

  task automatic test_gapped();
    bytes_t fb; int f, l; bus_ev_t ev; bit found;
    fb = make_frame(32'h0007_0003, 32'h0000_0015, 1'b0);
    send_frame(0, fb, 3, 5, f, l);
    cnt_a++;
    repeat (H_A + 4) @(negedge clk);
    checks++; if (l - f != NB - 1 + 5) begin failures++;
      $display("FAIL gapped_span got=%0d exp=%0d", l - f, NB - 1 + 5); end
    pop_ev(0, found, ev);
    checks++; if (!found || ev.edge_n != l + 1 || ev.addr !== 32'h0007_0003 || ev.data !== 32'h15) begin
      failures++;
      $display("FAIL gapped_write found=%0d edge=%0d addr=%h data=%h exp edge=%0d", found, ev.edge_n, ev.addr, ev.data, l + 1); end
    checks++; if (ev.rdy !== 1'b0 || ev.busy !== 1'b1) begin failures++;
      $display("FAIL gapped_issue_flags in_ready=%b busy=%b exp 0/1", ev.rdy, ev.busy); end
    checks++; if (q_a.size() != 0 || if_a.frame_count !== 16'(cnt_a)) begin failures++;
      $display("FAIL gapped_tail extra=%0d count=%0d exp 0/%0d", q_a.size(), if_a.frame_count, cnt_a); q_a.delete(); end
    $display("test_gapped span=%0d write_edge=%0d", l - f, ev.edge_n);
  endtask

  task automatic test_random();
    bytes_t fb; int f, l, ga, gl; bus_ev_t ev; bit found; logic [31:0] a, d;
    for (int n = 0; n < 6; n++) begin
      a  = rand_addr();
      d  = $urandom();
      ga = $urandom_range(0, NB - 2);
      gl = $urandom_range(0, 4);
      fb = make_frame(a, d, 1'b0);
      send_frame(0, fb, ga, gl, f, l);
      cnt_a++;
      repeat (H_A + 3) @(negedge clk);
      pop_ev(0, found, ev);
      checks++; if (!found || ev.edge_n != l + 1 || ev.addr !== a || ev.data !== d || q_a.size() != 0) begin
        failures++;
        $display("FAIL random_write n=%0d found=%0d edge=%0d addr=%h data=%h extra=%0d exp edge=%0d addr=%h data=%h",
                 n, found, ev.edge_n, ev.addr, ev.data, q_a.size(), l + 1, a, d);
        q_a.delete(); end
      checks++; if (if_a.frame_count !== 16'(cnt_a)) begin failures++;
        $display("FAIL random_count n=%0d got=%0d exp=%0d", n, if_a.frame_count, cnt_a); end
      $display("test_random n=%0d addr=%h data=%h gap=%0d@%0d", n, a, d, gl, ga);
    end
  endtask

  task automatic test_back_to_back();
    bytes_t f1, f2; int s1, l1, s2, l2, e1, e2; bus_ev_t ev; bit found;
    logic [31:0] a1, d1, a2, d2;
    a1 = rand_addr(); d1 = $urandom(); a2 = rand_addr(); d2 = $urandom();
    f1 = make_frame(a1, d1, 1'b0);
    f2 = make_frame(a2, d2, 1'b0);
    send_frame(1, f1, -1, 0, s1, l1);
    send_frame(1, f2, -1, 0, s2, l2);
    cnt_b += 2;
    repeat (H_B + 4) @(negedge clk);
    e1 = -1; e2 = -1;
    for (int k = 0; k < H_B; k++) begin
      pop_ev(1, found, ev);
      checks++; if (!found || ev.edge_n != l1 + 1 + k || ev.addr !== a1 || ev.data !== d1) begin failures++;
        $display("FAIL b2b_first k=%0d found=%0d edge=%0d addr=%h data=%h exp edge=%0d addr=%h data=%h",
                 k, found, ev.edge_n, ev.addr, ev.data, l1 + 1 + k, a1, d1); end
      e1 = ev.edge_n;
    end
    for (int k = 0; k < H_B; k++) begin
      pop_ev(1, found, ev);
      checks++; if (!found || ev.edge_n != l2 + 1 + k || ev.addr !== a2 || ev.data !== d2) begin failures++;
        $display("FAIL b2b_second k=%0d found=%0d edge=%0d addr=%h data=%h exp edge=%0d addr=%h data=%h",
                 k, found, ev.edge_n, ev.addr, ev.data, l2 + 1 + k, a2, d2); end
      if (k == 0) e2 = ev.edge_n;
    end
    checks++; if (e2 - e1 - 1 < 8) begin failures++;
      $display("FAIL b2b_idle_gap got=%0d exp>=8", e2 - e1 - 1); end
    checks++; if (q_b.size() != 0 || if_b.frame_count !== 16'(cnt_b)) begin failures++;
      $display("FAIL b2b_tail extra=%0d count=%0d exp 0/%0d", q_b.size(), if_b.frame_count, cnt_b); q_b.delete(); end
    $display("test_back_to_back idle_gap=%0d frame_count=%0d", e2 - e1 - 1, if_b.frame_count);
  endtask

  task automatic test_reset_mid_issue();
    bytes_t fb; int f, l; bus_ev_t ev; bit found; logic [31:0] a, d;
    a = rand_addr(); d = $urandom();
    fb = make_frame(a, d, 1'b0);
    send_frame(1, fb, -1, 0, f, l);
    while (edge_cnt < l + 2) @(negedge clk);
    checks++; if (if_b.config_addr !== a || if_b.busy !== 1'b1) begin failures++;
      $display("FAIL midissue_pre addr=%h busy=%b exp addr=%h busy=1", if_b.config_addr, if_b.busy, a); end
    #2;
    rst_b = 1'b1;
    #1;
    checks++; if (if_b.config_addr !== IDLE_A) begin failures++;
      $display("FAIL midissue_addr got=%h exp=%h", if_b.config_addr, IDLE_A); end
    checks++; if (if_b.frame_count !== 16'h0 || if_b.busy !== 1'b0) begin failures++;
      $display("FAIL midissue_status count=%0d busy=%b exp 0/0", if_b.frame_count, if_b.busy); end
    cnt_b = 0;
    @(negedge clk);
    q_b.delete();
    rst_b = 1'b0;
    @(negedge clk);
    a = rand_addr(); d = $urandom();
    fb = make_frame(a, d, 1'b0);
    send_frame(1, fb, -1, 0, f, l);
    cnt_b++;
    repeat (H_B + 3) @(negedge clk);
    for (int k = 0; k < H_B; k++) begin
      pop_ev(1, found, ev);
      checks++; if (!found || ev.edge_n != l + 1 + k || ev.addr !== a || ev.data !== d) begin failures++;
        $display("FAIL midissue_reload k=%0d found=%0d edge=%0d addr=%h exp edge=%0d addr=%h",
                 k, found, ev.edge_n, ev.addr, l + 1 + k, a); end
    end
    checks++; if (q_b.size() != 0 || if_b.frame_count !== 16'(cnt_b)) begin failures++;
      $display("FAIL midissue_tail extra=%0d count=%0d exp 0/%0d", q_b.size(), if_b.frame_count, cnt_b); q_b.delete(); end
    $display("test_reset_mid_issue reload_addr=%h count=%0d", a, if_b.frame_count);
  endtask

`ifdef CONFIG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bytes_t fb; int f, l; bus_ev_t ev; bit found; logic [31:0] a, d;
    a = rand_addr(); d = $urandom();
    fb = make_frame(a, d, 1'b1);
    send_frame(1, fb, -1, 0, f, l);
    repeat (H_B + 3) @(negedge clk);
    checks++; if (q_b.size() != 0 || if_b.err_count !== 8'd1 || if_b.frame_count !== 16'(cnt_b)) begin failures++;
      $display("FAIL csum_bad writes=%0d err=%0d count=%0d exp 0/1/%0d", q_b.size(), if_b.err_count, if_b.frame_count, cnt_b);
      q_b.delete(); end
    fb = make_frame(END_A, 32'h0, 1'b1);
    send_frame(1, fb, -1, 0, f, l);
    repeat (3) @(negedge clk);
    checks++; if (if_b.config_done !== 1'b0 || if_b.err_count !== 8'd2 || if_b.in_ready !== 1'b1) begin failures++;
      $display("FAIL csum_bad_end done=%b err=%0d ready=%b exp 0/2/1", if_b.config_done, if_b.err_count, if_b.in_ready); end
    a = rand_addr(); d = $urandom();
    fb = make_frame(a, d, 1'b0);
    send_frame(1, fb, -1, 0, f, l);
    cnt_b++;
    repeat (H_B + 3) @(negedge clk);
    pop_ev(1, found, ev);
    checks++; if (!found || ev.edge_n != l + 1 || ev.addr !== a || ev.data !== d) begin failures++;
      $display("FAIL csum_good found=%0d edge=%0d addr=%h exp edge=%0d addr=%h", found, ev.edge_n, ev.addr, l + 1, a); end
    q_b.delete();
    checks++; if (if_b.frame_count !== 16'(cnt_b)) begin failures++;
      $display("FAIL csum_count got=%0d exp=%0d", if_b.frame_count, cnt_b); end
    $display("test_checksum err_count=%0d frame_count=%0d", if_b.err_count, if_b.frame_count);
  endtask
`endif

  task automatic test_end_frame();
    bytes_t fb, fb2; int f, l; bit saw_ready;
    fb = make_frame(END_A, 32'h0, 1'b0);
    send_frame(0, fb, -1, 0, f, l);
    repeat (4) @(negedge clk);
    checks++; if (if_a.config_done !== 1'b1 || if_a.in_ready !== 1'b0) begin failures++;
      $display("FAIL end_flags done=%b in_ready=%b exp 1/0", if_a.config_done, if_a.in_ready); end
    checks++; if (q_a.size() != 0 || if_a.frame_count !== 16'(cnt_a)) begin failures++;
      $display("FAIL end_no_write writes=%0d count=%0d exp 0/%0d", q_a.size(), if_a.frame_count, cnt_a); q_a.delete(); end
    fb2 = make_frame(32'h0007_0003, 32'h0000_0015, 1'b0);
    saw_ready = 1'b0;
    for (int i = 0; i < 2 * NB; i++) begin
      @(negedge clk);
      drive(0, 1'b1, fb2[i % NB]);
      if (if_a.in_ready !== 1'b0) saw_ready = 1'b1;
    end
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    checks++; if (saw_ready) begin failures++;
      $display("FAIL end_in_ready got=1 exp=0 while stream offered"); end
    checks++; if (q_a.size() != 0 || if_a.frame_count !== 16'(cnt_a) || if_a.config_done !== 1'b1) begin failures++;
      $display("FAIL end_ignored writes=%0d count=%0d done=%b exp 0/%0d/1", q_a.size(), if_a.frame_count, if_a.config_done, cnt_a); end
    $display("test_end_frame done=%b frame_count=%0d", if_a.config_done, if_a.frame_count);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gapped();
    test_random();
    test_back_to_back();
    test_reset_mid_issue();
`ifdef CONFIG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_end_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Upstream of every PE tile. Turns a byte stream (from the board's SPI/UART front end) into the fabric-wide config_addr/config_data bus that all tiles decode.
- Each write frame is addr[31:0] followed by data[31:0], big-endian.
- Between writes the bus rests on an address that matches no tile unit, so tiles see exactly HOLD_CYCLES enable cycles per frame.
- An end-of-stream frame raises config_done.

Parameters:
- IDLE_ADDR, 32'hFFFF_FFFF, bus address driven whenever no write is issued; upper half matches no unit select (4..7).
- END_ADDR, 32'hFFFF_FFFE, frame address that terminates loading; never driven onto the bus.
- HOLD_CYCLES, 1, cycles a decoded write is held on the bus; range 1..15.

Ports:
- clk  in  1  fabric clock
- reset  in  1  asynchronous, active-high reset
- in_byte  in  8  stream byte
- in_valid  in  1  in_byte valid
- in_ready  out  1  loader accepts in_byte this cycle
- config_addr  out  32  broadcast config address to tiles
- config_data  out  32  broadcast config data to tiles
- config_done  out  1  END_ADDR frame received; sticky until reset
- busy  out  1  high in ISSUE state
- frame_count  out  16  number of frames issued to the bus (saturating)

Behaviour:
- Reset (async assert, sync release): config_addr=IDLE_ADDR, config_data=0, in_ready=0 in reset, then 1 in COLLECT; config_done=0, busy=0, frame_count=0, byte index=0.
- Byte transfer happens on a clock edge with in_valid && in_ready.
- COLLECT:
  - in_ready=1.
  - Bytes 0-3 shift into the addr shadow, MSB first; bytes 4-7 into the data shadow.
  - On the 8th byte: if addr==END_ADDR go to DONE, else go to ISSUE.
  - Shadows are internal; the bus stays IDLE_ADDR throughout.
- ISSUE:
  - in_ready=0, busy=1.
  - config_addr/config_data are registered from the shadows on entry.
  - Held for HOLD_CYCLES cycles, then the bus returns to IDLE_ADDR in the same edge that re-enters COLLECT.
  - config_data keeps its last value; it is not zeroed.
  - frame_count increments once per frame, saturating at 16'hFFFF.
- Latency: the 8th byte accepted at edge N puts the frame on the bus from edge N+1 through edge N+HOLD_CYCLES.
- No back-to-back writes without an IDLE_ADDR cycle between them. Minimum 8 COLLECT cycles per frame guarantees this.
- DONE:
  - in_ready=0, config_done=1, bus at IDLE_ADDR.
  - Remains in DONE until reset; further input is ignored and not consumed.
- in_valid dropping mid-frame: byte index holds and the partial frame is kept indefinitely; no timeout.
- Reset mid-ISSUE: bus goes to IDLE_ADDR immediately (asynchronous), partial state is discarded, frame_count=0.
- The END_ADDR frame's data bytes are consumed and discarded.

Optional Feature:
- Macro: CONFIG_LOADER_CHECKSUM_EN.
- Defined:
  - Frame grows to 9 bytes; byte 8 = XOR of bytes 0-7.
  - Mismatch: frame is not issued, stays in COLLECT, and err_count[7:0] increments (saturating).
  - An END frame with a bad checksum is treated as a normal dropped frame and does not end loading.
  - err_count is an extra output port; reset value 0.
- Undefined: 8-byte frames, no checksum, no err_count port.

Decomposition:
- Shared package config_pkg holds:
  - unit select constants CONFIG_SB=7, CONFIG_CB0=6, CONFIG_CB1=5, CONFIG_CLB=4;
  - IDLE_ADDR and END_ADDR defaults;
  - loader state enum {COLLECT, ISSUE, DONE};
  - FRAME_BYTES (8, or 9 with checksum).
- One natural sub-module: config_frame_assembler, covering the byte index, the shift registers for the shadows and the checksum, and a frame_ready pulse. The FSM and bus driver stay in config_loader.

Test Plan:
- Single frame: after reset, stream 00 07 00 03 00 00 00 15 with in_valid held high. Expect config_addr=32'h0007_0003 and config_data=32'h15 for exactly 1 cycle, one edge after the 8th byte. Then IDLE_ADDR; frame_count=1.
- Gapped stream: same frame with in_valid low for 5 cycles after byte 3. Expect an identical bus result, shifted later by 5 cycles, and in_ready=0 during ISSUE.
- Two back-to-back frames with HOLD_CYCLES=3:
  - each frame appears for 3 cycles;
  - at least 8 IDLE_ADDR cycles separate the two writes;
  - frame_count=2.
- End frame FF FF FF FE 00 00 00 00:
  - config_done=1 and in_ready=0 thereafter;
  - a following frame produces no bus activity;
  - frame_count unchanged.
- Reset asserted in the middle of ISSUE: config_addr=IDLE_ADDR within the same cycle (before the next edge), frame_count=0. After release, a new frame loads normally.
- With CONFIG_LOADER_CHECKSUM_EN defined:
  - a frame with a bad byte 8 gives no bus write and err_count=1;
  - the next valid frame then issues normally.
